// File: rtl/ntt_agu_pkg.sv
// Shared types and stage-bound helpers for the multi-lane NTT/INTT address generator.
// Bounds are derived from the transform geometry so every instance shares one definition.

package ntt_agu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } agu_state_e;

    // Inner counter i runs 0..2^(LOGN-RADIX_LOG*(l+1))-1 inside stage l.
    function automatic int i_upper(input int logn, input int rlog, input int l);
        return (1 << (logn - rlog * (l + 1))) - 1;
    endfunction

    // Outer counter j runs 0..2^(RADIX_LOG*l)-1 inside stage l.
    function automatic int j_upper(input int rlog, input int l);
        return (1 << (rlog * l)) - 1;
    endfunction

    function automatic int lanes_of(input int rlog);
        return 1 << rlog;
    endfunction

endpackage

// File: rtl/bit_rev_var.sv
// Combinational reversal of the low len_i bits of data_i; bits at or above len_i read as 0.
// len_i values above W are clamped to W.

module bit_rev_var #(
    parameter int W    = 12,
    parameter int LENW = $clog2(W + 1)
) (
    input  logic [W-1:0]    data_i,
    input  logic [LENW-1:0] len_i,
    output logic [W-1:0]    data_o
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    int effLen;
    int srcIdx;

    always_comb begin
        data_o = '0;
        srcIdx = 0;
        effLen = (int'(len_i) > W) ? W : int'(len_i);
        for (int k = 0; k < W; k++) begin
            if (k < effLen) begin
                srcIdx    = effLen - 1 - k;
                data_o[k] = data_i[IW'(srcIdx)];
            end
        end
    end

endmodule

// File: rtl/ntt_agu_multi.sv
// Multi-lane NTT/INTT address generator: one butterfly group (LANES orders) per accepted beat,
// walking every stage forward or inverse, with valid/ready backpressure and start/busy/done control.

module ntt_agu_multi
    import ntt_agu_pkg::*;
#(
    parameter int LOGN      = 12,
    parameter int RADIX_LOG = 4,
    parameter int AW        = LOGN
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic                                  inverse_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [lanes_of(RADIX_LOG)*AW-1:0]     order_o,
    output logic [$clog2(LOGN/RADIX_LOG):0]       stage_o,
    output logic [AW-1:0]                         tw_idx_o,
    output logic                                  last_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int STAGES = LOGN / RADIX_LOG;
    localparam int LANES  = lanes_of(RADIX_LOG);
    localparam int LW     = $clog2(STAGES) + 1;
    localparam int LENW   = $clog2(AW + 1);

    if ((LOGN % RADIX_LOG) != 0) begin : g_bad_param
        $error("ntt_agu_multi: LOGN must be a multiple of RADIX_LOG");
    end

    agu_state_e state_q, state_d;
    logic                  inv_q, inv_d;
    logic [AW-1:0]         i_q, i_d;
    logic [AW-1:0]         j_q, j_d;
    logic [LW-1:0]         l_q, l_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [LANES*AW-1:0]   order_q, order_d;
    logic [AW-1:0]         tw_q, tw_d;
    logic [LW-1:0]         stage_q;

    logic                  accept;
    logic [AW-1:0]         iBound, jBound, iBoundNext, jBoundNext;
    logic [LW-1:0]         lTerm;
    logic [LENW-1:0]       revLen;
    int                    hiShift;
    int                    loShift;

    // Counter sequencing: i innermost, then j, then the stage index in the latched direction.
    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        i_d     = i_q;
        j_d     = j_q;
        l_d     = l_q;
        done_d  = 1'b0;
        accept  = valid_q && out_ready_i;
        iBound  = AW'(i_upper(LOGN, RADIX_LOG, int'(l_q)));
        jBound  = AW'(j_upper(RADIX_LOG, int'(l_q)));

        case (state_q)
            IDLE: begin
                // The cycle carrying done still belongs to the finished sweep, so start is ignored.
                if (start_i && !done_q) begin
                    state_d = RUN;
                    inv_d   = inverse_i;
                    i_d     = '0;
                    j_d     = '0;
                    l_d     = inverse_i ? LW'(STAGES - 1) : '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        i_d     = '0;
                        j_d     = '0;
                        l_d     = '0;
                    end else if (i_q != iBound) begin
                        i_d = i_q + AW'(1);
                    end else begin
                        i_d = '0;
                        if (j_q != jBound) begin
                            j_d = j_q + AW'(1);
                        end else begin
                            j_d = '0;
                            l_d = inv_q ? (l_q - LW'(1)) : (l_q + LW'(1));
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    bit_rev_var #(
        .W    (AW),
        .LENW (LENW)
    ) u_twiddle_rev (
        .data_i (j_d),
        .len_i  (revLen),
        .data_o (tw_d)
    );

    // Next-beat payload is built from the next counter values so every output is a plain register.
    always_comb begin
        valid_d    = (state_d == RUN);
        revLen     = LENW'(RADIX_LOG * int'(l_d));
        hiShift    = LOGN - RADIX_LOG * int'(l_d);
        loShift    = hiShift - RADIX_LOG;
        iBoundNext = AW'(i_upper(LOGN, RADIX_LOG, int'(l_d)));
        jBoundNext = AW'(j_upper(RADIX_LOG, int'(l_d)));
        lTerm      = inv_d ? '0 : LW'(STAGES - 1);
        last_d     = valid_d && (i_d == iBoundNext) && (j_d == jBoundNext) && (l_d == lTerm);
    end

    for (genvar m = 0; m < LANES; m++) begin : g_lane
        assign order_d[m*AW +: AW] = (tw_d << hiShift) | (AW'(m) << loShift) | i_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            inv_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            l_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            order_q <= '0;
            tw_q    <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            i_q     <= i_d;
            j_q     <= j_d;
            l_q     <= l_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            order_q <= valid_d ? order_d : '0;
            tw_q    <= valid_d ? tw_d : '0;
            stage_q <= valid_d ? l_d : '0;
        end
    end

    assign out_valid_o = valid_q;
    assign order_o     = order_q;
    assign stage_o     = stage_q;
    assign tw_idx_o    = tw_q;
    assign last_o      = last_q;
    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;

endmodule

// File: tb/tb_ntt_agu_multi.sv
// Self-checking bench: LOGN=8/RADIX_LOG=4 instance against a beat-index model plus literals,
// and LOGN=12/4 and LOGN=10/2 instances checked for per-stage address permutations.

module tb_ntt_agu_multi;

   localparam int LOGN   = 8;
   localparam int RL     = 4;
   localparam int AW     = 8;
   localparam int STAGES = 2;
   localparam int LANES  = 16;
   localparam int BPS    = 16;
   localparam int TOTAL  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, inverse, outReady;
   logic valid, last, busy, done;
   logic [LANES*AW-1:0] order;
   logic [1:0]          stage;
   logic [AW-1:0]       tw;

   logic start12, valid12, last12, busy12, done12;
   logic [16*12-1:0] order12;
   logic [2:0]       stage12;
   logic [11:0]      tw12;

   logic start10, valid10, last10, busy10, done10;
   logic [4*10-1:0]  order10;
   logic [3:0]       stage10;
   logic [9:0]       tw10;

   ntt_agu_multi #(.LOGN(LOGN), .RADIX_LOG(RL), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .inverse_i(inverse),
      .out_valid_o(valid), .out_ready_i(outReady), .order_o(order), .stage_o(stage),
      .tw_idx_o(tw), .last_o(last), .busy_o(busy), .done_o(done)
   );

   ntt_agu_multi #(.LOGN(12), .RADIX_LOG(4), .AW(12)) dut12 (
      .clk_i(clk), .rst_i(rst), .start_i(start12), .inverse_i(1'b0),
      .out_valid_o(valid12), .out_ready_i(1'b1), .order_o(order12), .stage_o(stage12),
      .tw_idx_o(tw12), .last_o(last12), .busy_o(busy12), .done_o(done12)
   );

   ntt_agu_multi #(.LOGN(10), .RADIX_LOG(2), .AW(10)) dut10 (
      .clk_i(clk), .rst_i(rst), .start_i(start10), .inverse_i(1'b1),
      .out_valid_o(valid10), .out_ready_i(1'b1), .order_o(order10), .stage_o(stage10),
      .tw_idx_o(tw10), .last_o(last10), .busy_o(busy10), .done_o(done10)
   );

   int checks = 0;
   int fails  = 0;

   // One comparison: counts it, and reports a FAIL line with both values on mismatch.
   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit inv);
      start   = 1'b1;
      inverse = inv;
      tick();
      start   = 1'b0;
      inverse = 1'b0;
   endtask

   // Model: the k-th beat of a sweep, derived directly from the transform geometry.
   function automatic int bitrevN(input int v, input int nbits);
      int r = 0;
      for (int b = 0; b < nbits; b++)
         if (((v >> b) & 1) == 1) r |= 1 << (nbits - 1 - b);
      return r;
   endfunction

   function automatic int modelStage(input int k, input bit inv);
      int s = k / BPS;
      return inv ? (STAGES - 1 - s) : s;
   endfunction

   function automatic int modelTw(input int k, input bit inv);
      int l   = modelStage(k, inv);
      int isz = 1 << (LOGN - RL * (l + 1));
      return bitrevN((k % BPS) / isz, RL * l);
   endfunction

   function automatic logic [LANES*AW-1:0] modelOrder(input int k, input bit inv);
      logic [LANES*AW-1:0] r;
      int l   = modelStage(k, inv);
      int isz = 1 << (LOGN - RL * (l + 1));
      int i   = (k % BPS) % isz;
      int twv = modelTw(k, inv);
      for (int m = 0; m < LANES; m++)
         r[m*AW +: AW] = AW'(twv * (1 << (LOGN - RL * l)) + m * isz + i);
      return r;
   endfunction

   bit monOn = 1'b0;
   bit mBusy = 1'b0, mInv = 1'b0, mDoneExp = 1'b0;
   int mBeat = 0;
   int doneCount = 0;
   bit pValid = 1'b0, pReady = 1'b0, pRst = 1'b1;
   logic [LANES*AW-1:0] pOrder;
   logic [1:0]          pStage;
   logic [AW-1:0]       pTw;

   // Compare process: checks the main DUT every cycle, then advances the model from the inputs seen.
   always @(negedge clk) begin
      if (monOn) begin
         checkOutput("done", done, mDoneExp);
         checkOutput("busy", busy, mBusy);
         checkOutput("valid", valid, mBusy);
         if (mBusy) begin
            checkOutput($sformatf("order_b%0d", mBeat), order, modelOrder(mBeat, mInv));
            checkOutput($sformatf("stage_b%0d", mBeat), stage, modelStage(mBeat, mInv));
            checkOutput($sformatf("tw_b%0d", mBeat), tw, modelTw(mBeat, mInv));
            checkOutput($sformatf("last_b%0d", mBeat), last, (mBeat == TOTAL - 1));
         end else begin
            checkOutput("idle_order", order, 0);
            checkOutput("idle_stage", stage, 0);
            checkOutput("idle_tw", tw, 0);
            checkOutput("idle_last", last, 0);
         end
         if (pValid && !pReady && !pRst) begin
            checkOutput("stall_order", order, pOrder);
            checkOutput("stall_stage", stage, pStage);
            checkOutput("stall_tw", tw, pTw);
         end
         if (done === 1'b1) doneCount++;
         pValid = valid; pReady = outReady; pRst = rst;
         pOrder = order; pStage = stage; pTw = tw;
         if (rst) begin
            mBusy = 1'b0; mBeat = 0; mDoneExp = 1'b0;
         end else if (mBusy) begin
            mDoneExp = 1'b0;
            if (outReady) begin
               if (mBeat == TOTAL - 1) begin
                  mBusy = 1'b0; mDoneExp = 1'b1; mBeat = 0;
               end else begin
                  mBeat++;
               end
            end
         end else begin
            if (start && !mDoneExp) begin
               mBusy = 1'b1; mInv = inverse; mBeat = 0;
            end
            mDoneExp = 1'b0;
         end
      end
   end

   bit seen12 [3][4096];
   int beats12 [3];
   int last12Cnt = 0, tw12Err = 0, doneCnt12 = 0;
   bit seen10 [5][1024];
   int beats10 [5];
   int last10Cnt = 0, tw10Err = 0, doneCnt10 = 0;

   // Permutation collectors for the larger parameter sets.
   always @(negedge clk) begin
      if (valid12 === 1'b1) begin
         beats12[int'(stage12)]++;
         for (int m = 0; m < 16; m++) seen12[int'(stage12)][int'(order12[m*12 +: 12])] = 1'b1;
         if (last12) last12Cnt++;
         if (stage12 == 3'd0 && tw12 != 12'd0) tw12Err++;
      end
      if (valid10 === 1'b1) begin
         beats10[int'(stage10)]++;
         for (int m = 0; m < 4; m++) seen10[int'(stage10)][int'(order10[m*10 +: 10])] = 1'b1;
         if (last10) last10Cnt++;
         if (stage10 == 4'd0 && tw10 != 10'd0) tw10Err++;
      end
      if (done12 === 1'b1) doneCnt12++;
      if (done10 === 1'b1) doneCnt10++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int cnt;
      rst = 1'b1; start = 1'b0; inverse = 1'b0; outReady = 1'b1;
      start12 = 1'b0; start10 = 1'b0;
      tick();
      monOn = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_busy", busy, 0);

      checkOutput("model_b17_order", modelOrder(17, 0), 128'h8f8e8d8c_8b8a8988_87868584_83828180);
      checkOutput("model_b17_tw", modelTw(17, 0), 8);
      checkOutput("model_inv_b0_stage", modelStage(0, 1), 1);
      checkOutput("model_inv_b31_order", modelOrder(31, 1), 128'hffefdfcf_bfaf9f8f_7f6f5f4f_3f2f1f0f);

      $display("[TB] forward sweep");
      applyStimulus(1'b0);
      for (int k = 0; k < TOTAL; k++) begin
         @(negedge clk);
         case (k)
            0: begin
               checkOutput("fwd_b0_order", order, 128'hf0e0d0c0_b0a09080_70605040_30201000);
               checkOutput("fwd_b0_stage", stage, 0);
            end
            1: checkOutput("fwd_b1_order", order, 128'hf1e1d1c1_b1a19181_71615141_31211101);
            16: begin
               checkOutput("fwd_b16_order", order, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
               checkOutput("fwd_b16_stage", stage, 1);
            end
            17: begin
               checkOutput("fwd_b17_order", order, 128'h8f8e8d8c_8b8a8988_87868584_83828180);
               checkOutput("fwd_b17_tw", tw, 8);
            end
            30: checkOutput("fwd_b30_last", last, 0);
            31: begin
               checkOutput("fwd_b31_order", order, 128'hfffefdfc_fbfaf9f8_f7f6f5f4_f3f2f1f0);
               checkOutput("fwd_b31_last", last, 1);
               checkOutput("fwd_b31_tw", tw, 15);
            end
            default: ;
         endcase
         tick();
         if (k == 5) begin start = 1'b1; inverse = 1'b1; end
         if (k == 6) begin start = 1'b0; inverse = 1'b0; end
      end
      start = 1'b1;
      @(negedge clk);
      checkOutput("fwd_done_pulse", done, 1);
      tick();
      start = 1'b0;
      @(negedge clk);
      checkOutput("start_on_done_ignored", busy, 0);
      checkOutput("fwd_done_once", done, 0);

      $display("[TB] inverse sweep");
      tick();
      applyStimulus(1'b1);
      for (int k = 0; k < TOTAL; k++) begin
         @(negedge clk);
         case (k)
            0: begin
               checkOutput("inv_b0_order", order, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
               checkOutput("inv_b0_stage", stage, 1);
            end
            1: checkOutput("inv_b1_tw", tw, 8);
            16: begin
               checkOutput("inv_b16_order", order, 128'hf0e0d0c0_b0a09080_70605040_30201000);
               checkOutput("inv_b16_stage", stage, 0);
            end
            31: begin
               checkOutput("inv_b31_order", order, 128'hffefdfcf_bfaf9f8f_7f6f5f4f_3f2f1f0f);
               checkOutput("inv_b31_last", last, 1);
            end
            default: ;
         endcase
         tick();
      end
      @(negedge clk);
      checkOutput("inv_done_pulse", done, 1);
      tick();

      $display("[TB] idle reset");
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_reset_busy", busy, 0);

      $display("[TB] backpressure sweep");
      tick();
      applyStimulus(1'b0);
      n = 0;
      while (doneCount < 3 && n < 600) begin
         outReady = ($urandom_range(0, 9) >= 3);
         tick();
         n++;
      end
      outReady = 1'b1;
      checkOutput("bp_sweep_done", doneCount, 3);

      $display("[TB] mid-sweep reset");
      tick();
      applyStimulus(1'b0);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_valid", valid, 0);
      checkOutput("midrst_done", done, 0);
      repeat (5) tick();
      checkOutput("midrst_no_done", doneCount, 3);
      applyStimulus(1'b0);
      n = 0;
      while (doneCount < 4 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("restart_sweep_done", doneCount, 4);

      $display("[TB] parameter sweeps");
      start12 = 1'b1; start10 = 1'b1;
      tick();
      start12 = 1'b0; start10 = 1'b0;
      n = 0;
      while ((doneCnt12 == 0 || doneCnt10 == 0) && n < 3000) begin
         tick();
         n++;
      end
      checkOutput("p12_done", doneCnt12, 1);
      checkOutput("p10_done", doneCnt10, 1);
      checkOutput("p12_idle", busy12, 0);
      checkOutput("p10_idle", busy10, 0);
      checkOutput("p12_last_count", last12Cnt, 1);
      checkOutput("p10_last_count", last10Cnt, 1);
      checkOutput("p12_stage0_tw", tw12Err, 0);
      checkOutput("p10_stage0_tw", tw10Err, 0);
      for (int s = 0; s < 3; s++) begin
         cnt = 0;
         for (int a = 0; a < 4096; a++) cnt += int'(seen12[s][a]);
         checkOutput($sformatf("p12_perm_s%0d", s), cnt, 4096);
         checkOutput($sformatf("p12_beats_s%0d", s), beats12[s], 256);
      end
      for (int s = 0; s < 5; s++) begin
         cnt = 0;
         for (int a = 0; a < 1024; a++) cnt += int'(seen10[s][a]);
         checkOutput($sformatf("p10_perm_s%0d", s), cnt, 1024);
         checkOutput($sformatf("p10_beats_s%0d", s), beats10[s], 256);
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
